// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI link types and constants
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LAST
  } spiTxState_t;

  localparam int SYNC_STAGES = 2;

  // SPI mode shared with the receiver: data changes on sck rise, sampled on fall
  localparam logic SPI_LAUNCH_ON_RISE = 1'b1;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - pin synchronizer with rise/fall pulse flags
module sync_edge_detect
  import spi_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic rise,
  output logic fall
);

  // pipe[STAGES-1] is the synchronized level, pipe[STAGES] its one-cycle-old copy
  logic [STAGES:0] pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[STAGES-1:0], pin};
    end
  end

  assign rise = pipe[STAGES-1] & ~pipe[STAGES];
  assign fall = ~pipe[STAGES-1] & pipe[STAGES];

endmodule

// File: rtl/spi_transmit.sv
// rtl/spi_transmit.sv - SPI slave transmitter with one-entry holding buffer
module spi_transmit
  import spi_pkg::*;
#(
  parameter int messageBits = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sck,
  input  logic                   cs,
  input  logic [messageBits-1:0] txData,
  input  logic                   txValid,
  output logic                   txReady,
  output logic                   sdo,
  output logic                   txDone,
  output logic                   underrun,
  output logic                   aborted
);

  localparam int CW = $clog2(messageBits + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(messageBits);

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic sck_launch, sck_sample;

  spiTxState_t            state, state_n;
  logic [messageBits-1:0] shift_q, shift_n;
  logic [messageBits-1:0] buf_data, buf_data_n;
  logic                   buf_full, buf_full_n;
  logic [CW-1:0]          count, count_n;
  logic                   sdo_n, done_n, underrun_n, aborted_n;
  logic                   load, handshake;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (cs),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  assign sck_launch = SPI_LAUNCH_ON_RISE ? sck_rise : sck_fall;
  assign sck_sample = SPI_LAUNCH_ON_RISE ? sck_fall : sck_rise;
  assign txReady    = ~buf_full;
  assign handshake  = txValid & ~buf_full;

  always_comb begin
    state_n    = state;
    shift_n    = shift_q;
    count_n    = count;
    sdo_n      = sdo;
    done_n     = 1'b0;
    underrun_n = 1'b0;
    aborted_n  = 1'b0;
    load       = 1'b0;

    case (state)
      IDLE: begin
        sdo_n = 1'b0;
        if (cs_rise) begin
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_fall) begin
          aborted_n = 1'b1;
          sdo_n     = 1'b0;
          state_n   = IDLE;
        end else if (sck_launch) begin
          sdo_n   = shift_q[messageBits-1];
          shift_n = {shift_q[messageBits-2:0], 1'b0};
          count_n = count - CW'(1);
          if (count == CW'(1)) begin
            state_n = LAST;
          end
        end
      end
      LAST: begin
        // Every cs drop leaves via cs_fall, so cs is still high on a plain sck_sample
        if (cs_fall) begin
          done_n  = 1'b1;
          sdo_n   = 1'b0;
          state_n = IDLE;
        end else if (sck_sample) begin
          done_n  = 1'b1;
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      default: begin
        sdo_n   = 1'b0;
        state_n = IDLE;
      end
    endcase

    // A load sees the buffer as it was before any same-cycle handshake
    if (load) begin
      shift_n    = buf_full ? buf_data : '0;
      underrun_n = ~buf_full;
      count_n    = FULL_COUNT;
    end

    buf_full_n = handshake | (buf_full & ~load);
    buf_data_n = handshake ? txData : buf_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shift_q  <= '0;
      count    <= FULL_COUNT;
      buf_data <= '0;
      buf_full <= 1'b0;
      sdo      <= 1'b0;
      txDone   <= 1'b0;
      underrun <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      state    <= state_n;
      shift_q  <= shift_n;
      count    <= count_n;
      buf_data <= buf_data_n;
      buf_full <= buf_full_n;
      sdo      <= sdo_n;
      txDone   <= done_n;
      underrun <= underrun_n;
      aborted  <= aborted_n;
    end
  end

endmodule
